banco_ctrl: RTL
===============

# banco_ctrl

Write-port controller for the 16-entry colour register bank. It sits between the matrix keypad and the bank's write port. It debounces each key press and performs one read-modify-write per accepted press, advancing the stored colour of that cell by one with wrap-around. It also arbitrates the same write port for a full-bank clear sweep, so the VGA reader only ever sees whole, committed updates.

## Interface
- `ADDR_W`, default 4: bank address width; the bank depth is 2^ADDR_W.
- `DATA_W`, default 3: colour width (R, G, B bits).
- `DEB_CYCLES`, default 1000000: number of stable cycles required to accept a press or a release (20 ms at 50 MHz).

- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous and active-high.
- `key_pos`  in  ADDR_W: position of the pressed key, from the keypad scanner.
- `key_opr`  in  1: a key is pressed (raw, bouncing).
- `clr_req`  in  1: request to clear the whole bank (level or pulse).
- `rd_addr`  out  ADDR_W: read address on the bank's controller read port.
- `rd_data`  in  DATA_W: bank read data.
- `wr_en`  out  1: bank write enable, one cycle per write.
- `wr_addr`  out  ADDR_W: bank write address.
- `wr_data`  out  DATA_W: bank write data.
- `key_valid`  out  1: debounced "press accepted and held" level; intended for PWM gating.
- `busy`  out  1: high in every state except IDLE.

## Operation
- States: IDLE, DEBOUNCE, READ, WAIT_RD, WRITE, HOLD, CLEAR.
- IDLE:
  - If `clr_req` or `clr_pend` is set, go to CLEAR. Clear has priority over a simultaneous key press.
  - Otherwise, if `key_opr` is high, latch `pos_q` = `key_pos`, set `cnt` = 0 and go to DEBOUNCE.
- DEBOUNCE:
  - If `key_opr` is 0 or `key_pos` ≠ `pos_q`, go back to IDLE with no write.
  - When `cnt` reaches DEB_CYCLES-1, go to READ.
- READ: drive `rd_addr` = `pos_q`, then go to WAIT_RD.
- WAIT_RD: sample `rd_data` and compute `nxt` = (`rd_data`+1) mod 2^DATA_W, so 7 wraps to 0. Go to WRITE.
- WRITE: `wr_en` = 1, `wr_addr` = `pos_q`, `wr_data` = `nxt` for exactly one cycle, then go to HOLD.
- HOLD:
  - `key_valid` = 1 while `key_opr` is high.
  - The release counter resets whenever `key_opr` = 1.
  - After DEB_CYCLES consecutive cycles with `key_opr` = 0, go to IDLE.
  - A held key never produces a second write.
- CLEAR:
  - `wr_en` = 1 and `wr_data` = 0 on 2^ADDR_W consecutive cycles, with `wr_addr` counting 0 → 2^ADDR_W-1.
  - Then clear `clr_pend` and go to IDLE.
  - Key input is ignored during CLEAR.
- `clr_pend` is set when `clr_req` = 1 in any state other than IDLE, and is serviced on the next return to IDLE.
  - A request that arrives during DEBOUNCE through HOLD is deferred until the press sequence completes.
  - A request asserted during CLEAR is absorbed by the current sweep and does not cause a second sweep.
- `rd_addr` holds `pos_q` in READ and WAIT_RD and is 0 in all other states.
- Arithmetic: `cnt` width is $clog2(DEB_CYCLES); the increment is truncated to DATA_W.

## Timing
- Reset values: state IDLE; `wr_en`, `wr_addr`, `wr_data`, `rd_addr`, `key_valid`, `busy`, `clr_pend`, `cnt` and `pos_q` all 0. All outputs are registered.
- Latency from the first cycle `key_opr` = 1 (key held stable) to `wr_en`:
  - 1 cycle (IDLE→DEBOUNCE),
  - plus DEB_CYCLES (debounce),
  - plus 2 (READ, WAIT_RD),
  - total DEB_CYCLES + 3 cycles.
- The read port is sampled exactly 1 cycle after `rd_addr` is valid. This tolerates both a combinational and a single-registered bank read.
- A full clear takes 2^ADDR_W cycles of `wr_en` (16 by default). `busy` is high 1 cycle before the first write and falls the cycle after the last write.
- Reset asserted mid-sequence aborts immediately, with no further writes:
  - cells already cleared stay cleared;
  - a read-modify-write aborted before WRITE leaves its cell unchanged.
- Minimum spacing between two accepted presses: 2·DEB_CYCLES + 4 cycles.

## Structure
- A shared header/package holds the state encoding constants (3-bit localparams ST_IDLE…ST_CLEAR) and the default DEB_CYCLES. Top-level instantiations reuse these.
- One sub-module, `debounce_cnt`:
  - inputs: clear and enable;
  - output: terminal flag at DEB_CYCLES-1;
  - used for both the press and release debounce.
- The FSM and address sweep counter stay in `banco_ctrl`.

## Test plan
- DEB_CYCLES=4 in all tests; the bank model is preloaded with 0.
1. Press `key_pos`=5, held for 20 cycles → a single write: `wr_en` pulse at cycle 7 with `wr_addr`=5, `wr_data`=1. `key_valid` is high until the release is debounced.
2. Cell 5 preloaded with 7, press 5 → `wr_data`=0 (wrap-around).
3. Bounce: `key_opr` high 2 cycles, low 1, high 2, then low → no write; `busy` returns to 0.
4. `key_pos` changes 3→9 during DEBOUNCE while `key_opr` is held → the sequence restarts at 9; exactly one write, to address 9.
5. `clr_req` pulsed during HOLD → after the release debounce, 16 consecutive writes of 0 to addresses 0..15; `clr_pend` then 0. `clr_req` and `key_opr` asserted together in IDLE → the clear runs first.
6. `rst` asserted at the 6th CLEAR cycle → outputs are 0 in the same cycle; addresses 0..4 are 0 and 5..15 keep their preload values.

Source files
------------

// File: rtl/banco_pkg.sv
// banco_pkg: shared state encoding and defaults for the colour-bank write controller
package banco_pkg;
  localparam int DEB_CYCLES_DEF = 1000000;
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_READ     = 3'd2,
    ST_WAIT_RD  = 3'd3,
    ST_WRITE    = 3'd4,
    ST_HOLD     = 3'd5,
    ST_CLEAR    = 3'd6
  } state_e;
  function automatic int cnt_w(input int d);
    return d > 1 ? $clog2(d) : 1;
  endfunction
endpackage

// File: rtl/banco_ctrl_debounce_cnt.sv
// debounce_cnt: stability counter shared by press and release debounce; done flags DEB_CYCLES-1
module debounce_cnt
  import banco_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);
  localparam int CW = cnt_w(DEB_CYCLES);
  logic [CW-1:0] cnt_q;
  assign done = cnt_q == CW'(DEB_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en && !done) cnt_q <= cnt_q + CW'(1);
endmodule

// File: rtl/banco_ctrl.sv
// banco_ctrl: keypad-driven read-modify-write and full-clear arbiter for the colour bank write port
module banco_ctrl
  import banco_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 3,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] key_pos,
  input  logic              key_opr,
  input  logic              clr_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              key_valid,
  output logic              busy
);
  state_e state_q;
  logic [ADDR_W-1:0] pos_q, swp_q, rd_addr_q, wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic wr_en_q, key_valid_q, busy_q, clr_pend_q;
  logic deb_en, deb_clr, deb_done;
  assign rd_addr   = rd_addr_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign key_valid = key_valid_q;
  assign busy      = busy_q;
  // In HOLD a high key restarts the release count; elsewhere the counter sits at zero
  assign deb_en  = state_q == ST_DEBOUNCE || state_q == ST_HOLD;
  assign deb_clr = !deb_en || (state_q == ST_HOLD && key_opr);
  debounce_cnt #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk (clk),
    .rst (rst),
    .clr (deb_clr),
    .en  (deb_en),
    .done(deb_done)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= ST_IDLE;
      pos_q       <= '0;
      swp_q       <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      clr_pend_q  <= 1'b0;
    end else begin
      wr_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      key_valid_q <= 1'b0;
      if (clr_req && state_q != ST_IDLE && state_q != ST_CLEAR) clr_pend_q <= 1'b1;
      case (state_q)
        ST_IDLE:
          if (clr_req || clr_pend_q) begin
            state_q <= ST_CLEAR;
            swp_q   <= '0;
            busy_q  <= 1'b1;
          end else if (key_opr) begin
            state_q <= ST_DEBOUNCE;
            pos_q   <= key_pos;
            busy_q  <= 1'b1;
          end
        ST_DEBOUNCE:
          if (!key_opr || key_pos != pos_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (deb_done) begin
            state_q   <= ST_READ;
            rd_addr_q <= pos_q;
          end
        ST_READ: begin
          state_q   <= ST_WAIT_RD;
          rd_addr_q <= pos_q;
        end
        // rd_addr has been stable a full cycle here, so a registered bank read is ready too
        ST_WAIT_RD: begin
          state_q   <= ST_WRITE;
          wr_en_q   <= 1'b1;
          wr_addr_q <= pos_q;
          wr_data_q <= rd_data + DATA_W'(1);
        end
        ST_WRITE: begin
          state_q     <= ST_HOLD;
          key_valid_q <= key_opr;
        end
        ST_HOLD:
          if (!key_opr && deb_done) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else key_valid_q <= key_opr;
        ST_CLEAR:
          if (wr_en_q && wr_addr_q == '1) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            clr_pend_q <= 1'b0;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= swp_q;
            wr_data_q <= '0;
            swp_q     <= swp_q + ADDR_W'(1);
          end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
endmodule
